// File: rtl/tetris_input.sv
// tetris_input: button levels to one-shot game commands with DAS/ARR and gravity.
// Define TETRIS_INPUT_REPEAT_EN to enable auto-repeat of left/down/right.
module tetris_input #(
  parameter int DAS_CYCLES     = 15_000_000,
  parameter int ARR_CYCLES     = 2_500_000,
  parameter int GRAVITY_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       pause,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready
);

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_GRAV  = 3'd1;
  localparam logic [2:0] C_ROT   = 3'd2;
  localparam logic [2:0] C_LEFT  = 3'd3;
  localparam logic [2:0] C_RIGHT = 3'd4;
  localparam logic [2:0] C_DOWN  = 3'd5;

  localparam int MAXC = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam int GW   = $clog2(GRAVITY_CYCLES);

  localparam logic [CW-1:0] DAS_LAST = CW'(DAS_CYCLES - 1);
`ifdef TETRIS_INPUT_REPEAT_EN
  localparam logic [CW-1:0] ARR_LAST = CW'(ARR_CYCLES - 1);
`endif
  localparam logic [GW-1:0] GRV_LAST = GW'(GRAVITY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
`ifdef TETRIS_INPUT_REPEAT_EN
    DELAY,
    REPEAT
`else
    DELAY
`endif
  } state_t;

  typedef enum logic [1:0] {P_NONE, P_KEY, P_GRAV} pres_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    key, cur_key;
  logic          key_ev;

  logic [GW-1:0] gcnt, gcnt_n;
  logic          grav_ev;
  logic          key_pend, key_pend_n;
  logic [2:0]    key_code, key_code_n;
  logic          grav_pend, grav_pend_n;
  pres_t         pres, pres_n;
  logic          accept, down_acc;

  always_comb begin
    if (btn[3])      key = C_ROT;
    else if (btn[2]) key = C_LEFT;
    else if (btn[1]) key = C_DOWN;
    else if (btn[0]) key = C_RIGHT;
    else             key = C_NONE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_key <= C_NONE;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_key <= key;
    end
  end

  // cnt saturates in DELAY so a held rotate never wraps back to a match
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (key == C_NONE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == IDLE || key != cur_key) begin
      state_n = DELAY;
      cnt_n   = '0;
    end else begin
      case (state)
        DELAY: begin
`ifdef TETRIS_INPUT_REPEAT_EN
          if (cnt == DAS_LAST && key != C_ROT) begin
            state_n = REPEAT;
            cnt_n   = '0;
          end else
`endif
          if (cnt != DAS_LAST) cnt_n = cnt + CW'(1);
        end
`ifdef TETRIS_INPUT_REPEAT_EN
        REPEAT: begin
          if (cnt == ARR_LAST) cnt_n = '0;
          else                 cnt_n = cnt + CW'(1);
        end
`endif
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    key_ev = 1'b0;
    if (key != C_NONE) begin
      if (state == IDLE || key != cur_key)
        key_ev = 1'b1;
`ifdef TETRIS_INPUT_REPEAT_EN
      else if (state == DELAY && cnt == DAS_LAST && key != C_ROT)
        key_ev = 1'b1;
      else if (state == REPEAT && cnt == ARR_LAST)
        key_ev = 1'b1;
`endif
    end
  end

  assign accept   = cmd_valid && cmd_ready;
  assign down_acc = accept && pres == P_KEY && key_code == C_DOWN;
  assign grav_ev  = !pause && gcnt == GRV_LAST;

  always_comb begin
    if (grav_ev || down_acc) gcnt_n = '0;
    else if (pause)          gcnt_n = gcnt;
    else                     gcnt_n = gcnt + GW'(1);

    key_pend_n  = (key_pend && !(accept && pres == P_KEY)) || key_ev;
    key_code_n  = key_ev ? key : key_code;
    grav_pend_n = (grav_pend && !(accept && pres == P_GRAV)) || grav_ev;

    // a presented command is only replaced once accepted
    pres_n = pres;
    if (pres == P_NONE || accept) begin
      if (key_pend_n)       pres_n = P_KEY;
      else if (grav_pend_n) pres_n = P_GRAV;
      else                  pres_n = P_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt      <= '0;
      key_pend  <= 1'b0;
      key_code  <= C_NONE;
      grav_pend <= 1'b0;
      pres      <= P_NONE;
    end else begin
      gcnt      <= gcnt_n;
      key_pend  <= key_pend_n;
      key_code  <= key_code_n;
      grav_pend <= grav_pend_n;
      pres      <= pres_n;
    end
  end

  always_comb begin
    cmd_valid = pres != P_NONE;
    case (pres)
      P_KEY:   cmd = key_code;
      P_GRAV:  cmd = C_GRAV;
      default: cmd = C_NONE;
    endcase
  end

endmodule

// File: tb/tb_tetris_input.sv
// tb_tetris_input: directed stimulus, behavioural model plus literal checks.
// Follows TETRIS_INPUT_REPEAT_EN the same way the design does.
module tb_tetris_input;

  localparam int DAS  = 4;
  localparam int ARR  = 2;
  localparam int GRAV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       pause;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;

  always #5 clk = ~clk;

  tetris_input #(
    .DAS_CYCLES(DAS),
    .ARR_CYCLES(ARR),
    .GRAVITY_CYCLES(GRAV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .pause(pause),
    .cmd(cmd),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int n_valid[8];
  string phase;

  // model: held key and edges since press, gravity progress, two slots
  int m_key, m_h, m_g, m_kc, m_pres;
  bit m_kp, m_gp;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", phase, name, act, exp);
    end
  endtask

  function automatic int prio(input logic [3:0] b);
    if (b[3]) return 2;
    if (b[2]) return 3;
    if (b[1]) return 5;
    if (b[0]) return 4;
    return 0;
  endfunction

  function automatic int m_cmd();
    if (m_pres == 1) return m_kc;
    if (m_pres == 2) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_key = 0; m_h = 0; m_g = 0; m_kc = 0;
    m_pres = 0; m_kp = 0; m_gp = 0;
  endtask

  task automatic model_edge();
    int k, evc, acc_code;
    bit ev, gev, acc;
    k = prio(btn);
    ev = 0; evc = 0; gev = 0;
    acc = (m_pres != 0) && cmd_ready;
    acc_code = m_cmd();
    if (k == 0) begin
      m_key = 0; m_h = 0;
    end else if (k != m_key) begin
      ev = 1; evc = k; m_key = k; m_h = 0;
    end else begin
      m_h++;
`ifdef TETRIS_INPUT_REPEAT_EN
      if (k != 2 && (m_h == DAS || (m_h > DAS && (m_h - DAS) % ARR == 0))) begin
        ev = 1; evc = k;
      end
`endif
    end
    if (!pause) begin
      m_g++;
      if (m_g == GRAV) begin gev = 1; m_g = 0; end
    end
    if (acc && acc_code == 5) m_g = 0;
    if (acc) begin
      if (m_pres == 1) m_kp = 0;
      else m_gp = 0;
    end
    if (ev) begin m_kp = 1; m_kc = evc; end
    if (gev) m_gp = 1;
    if (m_pres == 0 || acc)
      m_pres = m_kp ? 1 : (m_gp ? 2 : 0);
  endtask

  task automatic tick(input int lit);
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check($sformatf("cmd@%0d", cyc), cmd, m_cmd());
    check($sformatf("valid@%0d", cyc), cmd_valid, m_pres != 0);
    if (cmd_valid) n_valid[cmd]++;
    if (lit >= 0) check($sformatf("lit@%0d", cyc), cmd, lit);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 8; i++) n_valid[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_cmd", cmd, 0);
    check("rst_valid", cmd_valid, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    clear_counts();
  endtask

  int t1[12];
  int rep_on;

  initial begin
    reset = 1'b1; btn = 4'b0; pause = 1'b0; cmd_ready = 1'b1;
`ifdef TETRIS_INPUT_REPEAT_EN
    rep_on = 1;
    t1 = '{3, 0, 0, 0, 3, 0, 3, 0, 3, 1, 3, 0};
`else
    rep_on = 0;
    t1 = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`endif

    phase = "repeat";
    do_reset();
    btn = 4'b0100;
    for (int i = 0; i < 12; i++) tick(t1[i]);
    btn = 4'b0;
    for (int i = 0; i < 8; i++) tick(-1);
    check("left_count", n_valid[3], rep_on ? 5 : 1);

    phase = "rotate";
    do_reset();
    btn = 4'b1000;
    for (int i = 0; i < 20; i++) tick(i == 0 ? 2 : -1);
    check("rot_count", n_valid[2], 1);
    btn = 4'b1100;
    for (int i = 0; i < 6; i++) tick(-1);
    check("rot_prio", n_valid[2], 1);
    check("rot_noleft", n_valid[3], 0);
    btn = 4'b0;

    phase = "keychg";
    do_reset();
    btn = 4'b0001;
    tick(4);
    btn = 4'b0101;
    tick(3);
    tick(0); tick(0); tick(0);
    tick(rep_on ? 3 : 0);
    btn = 4'b0;

    phase = "backpr";
    do_reset();
    cmd_ready = 1'b0;
    btn = 4'b0001;
    tick(4);
    btn = 4'b0;
    for (int i = 0; i < 24; i++) tick(4);
    cmd_ready = 1'b1;
    tick(1);
    tick(0);
    check("grav_once", n_valid[1], 1);

    phase = "gravity";
    do_reset();
    for (int e = 1; e <= 26; e++) tick((e == 10 || e == 20) ? 1 : -1);
    btn = 4'b0010;
    tick(5);
    btn = 4'b0;
    for (int e = 28; e <= 38; e++) tick(e == 30 ? 0 : (e == 38 ? 1 : -1));
    pause = 1'b1;
    clear_counts();
    for (int i = 0; i < 25; i++) tick(-1);
    check("paused", n_valid[1], 0);
    pause = 1'b0;

    phase = "asyncrst";
    do_reset();
    btn = 4'b0001;
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_cmd", cmd, 0);
    model_reset();
    btn = 4'b0010;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    clear_counts();
    for (int i = 0; i < 12; i++) tick(i == 0 ? 5 : -1);
    check("down_count", n_valid[5], rep_on ? 5 : 1);
    btn = 4'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tetris_input.md
# tetris_input

Command generator between the four debounced push-buttons and the tetris game core. It turns held button levels into one-shot game commands with delayed auto-repeat (DAS/ARR). It also produces periodic gravity commands. Commands are merged through a valid/ready handshake, so no event is lost while the core is busy.

## Interface
- DAS_CYCLES, 15_000_000: clocks a movement button must stay held after its first command before auto-repeat starts (≥2).
- ARR_CYCLES, 2_500_000: clocks between auto-repeat commands (≥2).
- GRAVITY_CYCLES, 25_000_000: clocks between gravity commands (≥2).
- clk  in  1  system clock (50 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- btn  in  4  debounced levels: [3] rotate, [2] left, [1] down, [0] right.
- pause  in  1  level; while high, the gravity counter holds its value and no new gravity event is raised.
- cmd  out  3  command code: 0 none, 1 gravity, 2 rotate, 3 left, 4 right, 5 down.
- cmd_valid  out  1  cmd holds a command awaiting acceptance.
- cmd_ready  in  1  core accepts cmd when cmd_valid && cmd_ready at a rising edge.

## Operation
- Active key: the highest-priority held button, in the order rotate > left > down > right. If no button is held, there is no active key.
- Key FSM states are IDLE, DELAY and REPEAT, with a counter cnt.
  - IDLE: when an active key appears, raise a key event and go to DELAY with cnt=0.
  - DELAY: cnt increments each clock. When cnt==DAS_CYCLES-1 and the key is not rotate, raise a key event and go to REPEAT with cnt=0. Rotate stays in DELAY and never repeats.
  - REPEAT: cnt increments. When cnt==ARR_CYCLES-1, raise a key event and reset cnt=0.
  - Active key goes to none, from any state: go to IDLE, cnt=0, no event.
  - Active key changes to a different key: raise an event for the new key, go to DELAY, cnt=0.
- Gravity counter gcnt increments when pause is low. When gcnt==GRAVITY_CYCLES-1, it raises a gravity event and reloads to 0.
- Acceptance of a down command (cmd 5) reloads gcnt to 0. A soft drop therefore postpones gravity.
- Pending slots, one each:
  - Key slot: a new key event overwrites any unaccepted key event (latest wins).
  - Gravity slot: saturates; repeated gravity events while pending collapse into one.
- Output arbitration: the key slot has priority over the gravity slot.
  - Once cmd_valid is high, cmd and cmd_valid stay stable until accepted. The one exception is a key-slot overwrite, which may change cmd while the key command is the one presented.
  - A gravity command that is already presented is not preempted by a key event. The key event waits in its slot.
- On acceptance, the presented slot clears. If the other slot is pending, it is presented on the next cycle; otherwise cmd_valid=0 and cmd=0.

## Timing
- Reset values: cmd=0, cmd_valid=0, FSM=IDLE, cnt=0, gcnt=0, both slots empty.
- Latency from the first rising edge sampling a new active key to cmd_valid=1 with the key code: 1 clock, when the output is free.
- Event and acceptance in the same clock: the accepted slot clears and the new event is stored. The new event is presented the next cycle.
- Acceptance of a key command in the same clock as a new key event: the new key event is retained, not cleared.
- Reset asserted mid-operation: all state clears immediately, and pending commands are discarded.
- After reset deasserts with a button held, that button is treated as a new press at the first clock.
- btn is already synchronous, so no extra synchronizer stage is required.

## Configuration
- TETRIS_INPUT_REPEAT_EN defined: DAS/ARR auto-repeat for left, down and right, as described above.
- TETRIS_INPUT_REPEAT_EN undefined:
  - The REPEAT state is removed.
  - A held key stays in DELAY indefinitely and produces exactly one command per press or key change.
  - DAS_CYCLES and ARR_CYCLES are ignored.

## Test plan
Test parameters: DAS=4, ARR=2, GRAVITY=10, cmd_ready=1 unless stated.
- Reset, then hold btn[2] for 12 clocks, with REPEAT_EN defined → cmd=3 at clocks 1, 5, 7, 9 and 11. Released → no further commands.
- Hold btn[3] for 20 clocks → exactly one cmd=2. Then press btn[2] while btn[3] is still held → no new command, because rotate keeps priority.
- Key change: hold btn[0] → cmd=4. Add btn[2] → cmd=3 the next cycle, and the DAS restarts.
- Backpressure: cmd_ready=0, press btn[0] → cmd=4 held. Run for 25 clocks → gravity is pending once. Set cmd_ready=1 → cmd=4, then cmd=1, then cmd_valid=0.
- Gravity reload: with no buttons, cmd=1 every 10 clocks. Accept a down command at gcnt=7 → the next cmd=1 arrives 10 clocks after that acceptance. pause=1 → no gravity.
- Assert reset while cmd_valid=1 → cmd_valid=0 and cmd=0 asynchronously. Without TETRIS_INPUT_REPEAT_EN, holding btn[1] gives a single cmd=5.
